// File: rtl/transmission8_link.sv
// Registered 8-channel time-multiplexed link: an 8:1 mux stage feeds a single-bit
// wire that a 1:8 demux stage delivers back onto the same channel; unselected lines idle.
module transmission8_link #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] iData,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic [WIDTH-1:0] oData
);

    logic [2:0]       sel_d;
    logic [2:0]       sel_q;
    logic             bit_d;
    logic             bit_q;
    logic [WIDTH-1:0] oData_d;
    logic [WIDTH-1:0] oData_q;

    // Stage 1: the channel select and its data bit are sampled together.
    always_comb begin
        sel_d = {A, B, C};
        bit_d = iData[sel_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= IDLE_LEVEL;
            sel_q <= 3'd0;
        end else begin
            bit_q <= bit_d;
            sel_q <= sel_d;
        end
    end

    // Stage 2: only the captured channel carries the bit; the others idle.
    always_comb begin
        oData_d = {WIDTH{IDLE_LEVEL}};
        for (int i = 0; i < WIDTH; i++) begin
            if (3'(i) == sel_q) begin
                oData_d[i] = bit_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oData_q <= {WIDTH{IDLE_LEVEL}};
        end else begin
            oData_q <= oData_d;
        end
    end

    assign oData = oData_q;

endmodule

// File: tb/tb_transmission8_link.sv
// Scoreboard bench for transmission8_link: stimulus pushes hand-computed results
// with their due cycle, and a negedge monitor pops and compares them.
module tb_transmission8_link;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       A     = 1'b0;
    logic       B     = 1'b0;
    logic       C     = 1'b0;
    logic [7:0] oData;

    transmission8_link dut (
        .clk  (clk),
        .rst  (rst),
        .iData(iData),
        .A    (A),
        .B    (B),
        .C    (C),
        .oData(oData)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int         due;
        logic [7:0] exp;
        string      name;
    } expT;

    expT expQ[$];
    expT monE;
    int  total = 0;
    int  bad   = 0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: oData=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the result is due two rising edges later.
    task automatic applyStimulus(input logic [7:0] data, input logic [2:0] sel,
                                 input logic [7:0] exp, input string name);
        expT e;
        @(negedge clk);
        iData     = data;
        {A, B, C} = sel;
        e.due  = cycle + 2;
        e.exp  = exp;
        e.name = name;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].due <= cycle) begin
            monE = expQ.pop_front();
            checkOutput(monE.name, oData, monE.exp);
        end
    end

    logic [7:0] expAA[8] = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hEF, 8'hFF, 8'hBF, 8'hFF};
    logic [7:0] exp55[8] = '{8'hFF, 8'hFD, 8'hFF, 8'hF7, 8'hFF, 8'hDF, 8'hFF, 8'h7F};

    initial begin
        $display("[TB] start");

        // Asynchronous reset before any clock edge, then held across edges.
        #1 rst = 1'b1;
        iData = 8'hAA;
        #1 checkOutput("reset_async", oData, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 checkOutput("reset_hold", oData, 8'hFF);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(8'hAA, 3'(i), expAA[i], "sweepAA");
        for (int i = 0; i < 8; i++) applyStimulus(8'h55, 3'(i), exp55[i], "sweep55");

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) applyStimulus(8'h00, 3'd5, 8'hDF, "toggle00");
            else            applyStimulus(8'hFF, 3'd5, 8'hFF, "toggleFF");
        end

        // Short reset pulse while a zero bit for channel 2 is still in flight.
        applyStimulus(8'hAA, 3'd0, 8'hFE, "preRst0");
        applyStimulus(8'hAA, 3'd1, 8'hFF, "preRst1");
        applyStimulus(8'hAA, 3'd2, 8'hFB, "preRst2");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("rst_pulse", oData, 8'hFF);
        expQ.delete();
        #1 rst = 1'b0;
        applyStimulus(8'hAA, 3'd6, 8'hBF, "postRstFirst");
        @(posedge clk);
        #1 checkOutput("postRst_edge1", oData, 8'hFF);
        applyStimulus(8'hAA, 3'd4, 8'hEF, "postRstSecond");

        // Select glitches between edges must not reach the registered output.
        for (int i = 0; i < 3; i++) applyStimulus(8'hAA, 3'd2, 8'hFB, "glitchPre");
        #1 {A, B, C} = 3'd7;
        #1 checkOutput("glitch_sel7", oData, 8'hFB);
        {A, B, C} = 3'd0;
        iData = 8'h00;
        #1 checkOutput("glitch_sel0", oData, 8'hFB);
        {A, B, C} = 3'd2;
        iData = 8'hAA;
        for (int i = 0; i < 2; i++) applyStimulus(8'hAA, 3'd2, 8'hFB, "glitchPost");
        applyStimulus(8'hFF, 3'd3, 8'hFF, "mixFF");
        applyStimulus(8'h00, 3'd7, 8'h7F, "mix00");

        repeat (4) @(posedge clk);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
